hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Drives write-enables and flushes of
//  PC, fetch/decode, decode/execute, execute/memory and memory/writeback pipeline

---
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, branch flushes,
// data-memory wait states with timeout, and EX-stage operand forwarding.
module hazard_ctrl #(
    parameter int M       = 4,
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] regScr_D1,
    input  logic [M-1:0] regScr_D2,
    input  logic [M-1:0] regScr_E1,
    input  logic [M-1:0] regScr_E2,
    input  logic [M-1:0] regDst_E,
    input  logic         regw_E,
    input  logic         regmem_E,
    input  logic [M-1:0] regDst_M,
    input  logic         regw_M,
    input  logic [M-1:0] regDst_W,
    input  logic         regw_W,
    input  logic         pcsrc_E,
    input  logic         memreq_M,
    input  logic         memack,
    output logic         en_PC,
    output logic         en_FD,
    output logic         en_DE,
    output logic         en_EM,
    output logic         en_MW,
    output logic         clr_FD,
    output logic         clr_DE,
    output logic [1:0]   fwdA_E,
    output logic [1:0]   fwdB_E,
    output logic         err
);
    typedef enum logic [1:0] {RUN, MWAIT, ERR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          lduse, membusy, apply;

    assign lduse   = regmem_E & regw_E & ((regDst_E == regScr_D1) | (regDst_E == regScr_D2));
    assign membusy = memreq_M & ~memack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        apply   = 1'b0;
        en_PC   = 1'b0;
        en_FD   = 1'b0;
        en_DE   = 1'b0;
        en_EM   = 1'b0;
        en_MW   = 1'b0;
        clr_FD  = 1'b0;
        clr_DE  = 1'b0;
        case (state_q)
            RUN: begin
                if (membusy) begin
                    state_d = MWAIT;
                    cnt_d   = CW'(1);
                end else begin
                    apply = 1'b1;
                end
            end
            MWAIT: begin
                if (memack) begin
                    apply   = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ERR:     err_d = 1'b1;
            default: state_d = RUN;
        endcase

        // Branch flush outranks the load-use bubble: the dependent instr is squashed anyway.
        if (apply && rst) begin
            if (pcsrc_E) begin
                {en_PC, en_FD, en_DE, en_EM, en_MW} = 5'b11111;
                clr_FD = 1'b1;
                clr_DE = 1'b1;
            end else if (lduse) begin
                {en_PC, en_FD, en_DE, en_EM, en_MW} = 5'b00111;
                clr_DE = 1'b1;
            end else begin
                {en_PC, en_FD, en_DE, en_EM, en_MW} = 5'b11111;
            end
        end
    end

    always_comb begin
        fwdA_E = 2'b00;
        fwdB_E = 2'b00;
        if (rst) begin
            if (regw_M && regDst_M == regScr_E1)      fwdA_E = 2'b10;
            else if (regw_W && regDst_W == regScr_E1) fwdA_E = 2'b01;
            if (regw_M && regDst_M == regScr_E2)      fwdB_E = 2'b10;
            else if (regw_W && regDst_W == regScr_E2) fwdB_E = 2'b01;
        end
    end

    assign err = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected output vectors are queued when a
// step is driven and popped/checked when the DUT outputs are sampled.
module tb_hazard_ctrl;
    localparam int M = 4, TIMEOUT = 15, CW = 4;

    logic         clk = 1'b0, rst = 1'b0;
    logic [M-1:0] regScr_D1, regScr_D2, regScr_E1, regScr_E2, regDst_E, regDst_M, regDst_W;
    logic         regw_E, regmem_E, regw_M, regw_W, pcsrc_E, memreq_M, memack;
    logic         en_PC, en_FD, en_DE, en_EM, en_MW, clr_FD, clr_DE, err;
    logic [1:0]   fwdA_E, fwdB_E;

    typedef struct {
        string      tag;
        logic [11:0] exp;
    } sb_t;
    sb_t sbq[$];
    int  n_cmp = 0, n_bad = 0;

    hazard_ctrl #(.M(M), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .regScr_D1(regScr_D1), .regScr_D2(regScr_D2),
        .regScr_E1(regScr_E1), .regScr_E2(regScr_E2),
        .regDst_E(regDst_E), .regw_E(regw_E), .regmem_E(regmem_E),
        .regDst_M(regDst_M), .regw_M(regw_M),
        .regDst_W(regDst_W), .regw_W(regw_W),
        .pcsrc_E(pcsrc_E), .memreq_M(memreq_M), .memack(memack),
        .en_PC(en_PC), .en_FD(en_FD), .en_DE(en_DE), .en_EM(en_EM), .en_MW(en_MW),
        .clr_FD(clr_FD), .clr_DE(clr_DE), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .err(err)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {en[4:0] PC..MW, clr_FD, clr_DE, fwdA, fwdB, err}
    function automatic logic [11:0] ev(logic [4:0] en, logic cf, logic cd,
                                       logic [1:0] fa, logic [1:0] fb, logic e);
        return {en, cf, cd, fa, fb, e};
    endfunction

    task automatic push(input string tag, input logic [11:0] exp);
        sb_t s;
        s.tag = tag;
        s.exp = exp;
        sbq.push_back(s);
    endtask

    task automatic pop_cmp();
        sb_t s;
        logic [11:0] obs;
        obs = {en_PC, en_FD, en_DE, en_EM, en_MW, clr_FD, clr_DE, fwdA_E, fwdB_E, err};
        n_cmp++;
        if (sbq.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty observed=%h required=queued entry", obs);
        end else begin
            s = sbq.pop_front();
            assert (obs === s.exp) else begin
                n_bad++;
                $error("FAIL %s observed=%b required=%b", s.tag, obs, s.exp);
            end
        end
    endtask

    // Inputs are driven just after a rising edge; outputs are checked at the falling edge.
    task automatic step(input string tag, input logic [11:0] exp);
        push(tag, exp);
        @(negedge clk);
        pop_cmp();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [11:0] exp);
        push(tag, exp);
        #1;
        pop_cmp();
    endtask

    initial begin
        {regScr_D1, regScr_D2, regScr_E1, regScr_E2, regDst_E, regDst_M, regDst_W} = '0;
        {regw_E, regmem_E, regw_W, pcsrc_E, memreq_M, memack} = '0;
        regw_M = 1'b1;
        pcsrc_E = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_outputs", ev(5'b00000, 0, 0, 2'b00, 2'b00, 0));
        regw_M = 1'b0;
        pcsrc_E = 1'b0;
        rst = 1'b1;
        check_now("release_all_en", ev(5'b11111, 0, 0, 2'b00, 2'b00, 0));
        @(posedge clk);
        #1;

        // load-use: one bubble, then the load has moved on
        regmem_E = 1; regw_E = 1; regDst_E = 4'd3; regScr_D2 = 4'd3; regScr_D1 = 4'd7;
        step("lduse_stall", ev(5'b00111, 0, 1, 2'b00, 2'b00, 0));
        regmem_E = 0; regw_E = 0;
        step("lduse_after", ev(5'b11111, 0, 0, 2'b00, 2'b00, 0));
        regmem_E = 1; regw_E = 1; regDst_E = 4'd7;
        step("lduse_src1", ev(5'b00111, 0, 1, 2'b00, 2'b00, 0));
        regw_E = 0;
        step("load_no_write", ev(5'b11111, 0, 0, 2'b00, 2'b00, 0));

        // branch taken with load-use in the same cycle
        regw_E = 1; pcsrc_E = 1;
        step("branch_over_lduse", ev(5'b11111, 1, 1, 2'b00, 2'b00, 0));
        {regmem_E, regw_E, pcsrc_E} = '0;
        regDst_E = 4'd0; regScr_D1 = 4'd1; regScr_D2 = 4'd2;

        // memory wait: 3 frozen cycles, then ack
        memreq_M = 1; memack = 0;
        for (int i = 0; i < 3; i++) step("mwait_freeze", ev(5'b00000, 0, 0, 2'b00, 2'b00, 0));
        memack = 1;
        step("mwait_ack", ev(5'b11111, 0, 0, 2'b00, 2'b00, 0));
        memreq_M = 0; memack = 0;
        step("back_in_run", ev(5'b11111, 0, 0, 2'b00, 2'b00, 0));
        memreq_M = 1; memack = 1;
        step("ack_same_cycle", ev(5'b11111, 0, 0, 2'b00, 2'b00, 0));

        // branch pending during a wait is honoured on the ack cycle
        memack = 0; pcsrc_E = 1;
        step("branch_frozen0", ev(5'b00000, 0, 0, 2'b00, 2'b00, 0));
        step("branch_frozen1", ev(5'b00000, 0, 0, 2'b00, 2'b00, 0));
        memack = 1;
        step("branch_on_ack", ev(5'b11111, 1, 1, 2'b00, 2'b00, 0));
        pcsrc_E = 0; memreq_M = 0; memack = 0;
        @(posedge clk);
        #1;

        // timeout: TIMEOUT+1 frozen cycles without err, then sticky err
        memreq_M = 1; memack = 0;
        for (int i = 0; i <= TIMEOUT; i++) step("timeout_wait", ev(5'b00000, 0, 0, 2'b00, 2'b00, 0));
        step("timeout_err", ev(5'b00000, 0, 0, 2'b00, 2'b00, 1));
        memack = 1; memreq_M = 0;
        step("err_sticky", ev(5'b00000, 0, 0, 2'b00, 2'b00, 1));
        rst = 0;
        check_now("err_async_clear", ev(5'b00000, 0, 0, 2'b00, 2'b00, 0));
        #1 rst = 1;
        memack = 0;
        step("err_recover", ev(5'b11111, 0, 0, 2'b00, 2'b00, 0));

        // reset asserted mid-wait aborts without a clock edge
        memreq_M = 1;
        step("abort_wait0", ev(5'b00000, 0, 0, 2'b00, 2'b00, 0));
        step("abort_wait1", ev(5'b00000, 0, 0, 2'b00, 2'b00, 0));
        rst = 0;
        check_now("abort_rst_low", ev(5'b00000, 0, 0, 2'b00, 2'b00, 0));
        #1 rst = 1; memreq_M = 0;
        step("abort_run", ev(5'b11111, 0, 0, 2'b00, 2'b00, 0));

        // forwarding
        regw_M = 1; regw_W = 1; regDst_M = 4'd5; regDst_W = 4'd5; regScr_E1 = 4'd5; regScr_E2 = 4'd6;
        step("fwd_mem_wins", ev(5'b11111, 0, 0, 2'b10, 2'b00, 0));
        regw_M = 0;
        step("fwd_wb", ev(5'b11111, 0, 0, 2'b01, 2'b00, 0));
        regw_M = 1; regDst_M = 4'd6;
        step("fwd_split", ev(5'b11111, 0, 0, 2'b01, 2'b10, 0));
        regw_W = 0; regw_M = 0;
        step("fwd_none", ev(5'b11111, 0, 0, 2'b00, 2'b00, 0));
        regw_M = 1; memreq_M = 1;
        step("fwd_in_wait", ev(5'b00000, 0, 0, 2'b00, 2'b10, 0));
        memack = 1;
        step("fwd_wait_ack", ev(5'b11111, 0, 0, 2'b00, 2'b10, 0));

        if (sbq.size() != 0) begin
            n_bad++;
            $error("FAIL sb_leftover observed=%0d required=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
